// File: rtl/tft_cmd_queue.sv
// Command FIFO and init/draw pulse sequencer in front of tft_ctrl.
// Optional write-side window clipping is built when TFT_CMD_CLIP_EN is defined.
module tft_cmd_queue #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AUTO_INIT  = 1,
    parameter int unsigned BUSY_TMO   = 7,
    parameter int unsigned XMAX       = 239,
    parameter int unsigned YMAX       = 319
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  wr_en,
    input  logic [15:0]           wr_color,
    input  logic [15:0]           wr_xstart,
    input  logic [15:0]           wr_xend,
    input  logic [15:0]           wr_ystart,
    input  logic [15:0]           wr_yend,
    input  logic                  init_req,

    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,

    output logic                  init,
    output logic                  draw,
    input  logic                  ctrl_busy,
    output logic [15:0]           color,
    output logic [15:0]           xstart,
    output logic [15:0]           xend,
    output logic [15:0]           ystart,
    output logic [15:0]           yend,

    output logic                  idle,
    output logic                  tmo_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned TMO_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(BUSY_TMO - 1);
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2 + 1)'(1);

    if (DEPTH_LOG2 < 1 || BUSY_TMO < 1 || XMAX > 32'hFFFF || YMAX > 32'hFFFF) begin : g_bad_param
        $error("tft_cmd_queue: parameter out of range");
    end

    typedef struct packed {
        logic [15:0] color;
        logic [15:0] xs;
        logic [15:0] xe;
        logic [15:0] ys;
        logic [15:0] ye;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitHi,
        StWaitLo,
        StGap
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Write-side entry formation
    // ---------------------------------------------------------------------------------------
    entry_t wr_entry;
    logic   wr_drop;

`ifdef TFT_CMD_CLIP_EN
    localparam logic [15:0] XMAX_W = 16'(XMAX);
    localparam logic [15:0] YMAX_W = 16'(YMAX);

    logic [15:0] x_lo, x_hi, y_lo, y_hi;

    always_comb begin
        x_lo = (wr_xstart > wr_xend) ? wr_xend   : wr_xstart;
        x_hi = (wr_xstart > wr_xend) ? wr_xstart : wr_xend;
        y_lo = (wr_ystart > wr_yend) ? wr_yend   : wr_ystart;
        y_hi = (wr_ystart > wr_yend) ? wr_ystart : wr_yend;

        wr_entry.color = wr_color;
        wr_entry.xs    = x_lo;
        wr_entry.xe    = (x_hi > XMAX_W) ? XMAX_W : x_hi;
        wr_entry.ys    = y_lo;
        wr_entry.ye    = (y_hi > YMAX_W) ? YMAX_W : y_hi;

        // A window starting off-screen has nothing left to draw.
        wr_drop = (x_lo > XMAX_W) || (y_lo > YMAX_W);
    end
`else
    assign wr_entry = '{color: wr_color, xs: wr_xstart, xe: wr_xend,
                        ys: wr_ystart, ye: wr_yend};
    assign wr_drop  = 1'b0;
`endif

    // ---------------------------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------------------------
    entry_t              mem [DEPTH];
    entry_t              head;
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                push;
    logic                pop;

    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign push     = wr_en && !wr_drop && (!full_q || pop);
    assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    assign empty_d  = (wr_ptr_d == rd_ptr_d);
    assign full_d   = (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]) &&
                      (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
    assign head     = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_entry;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
    logic             init_pend_q, init_pend_d;
    logic             init_q, init_d;
    logic             draw_q, draw_d;
    logic             issue_init;
    entry_t           out_q;

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_err_d  = tmo_err_q;
        init_d     = 1'b0;
        draw_d     = 1'b0;
        issue_init = 1'b0;
        pop        = 1'b0;

        case (state_q)
            StIdle: begin
                tmo_cnt_d = '0;
                if (init_pend_q) begin
                    issue_init = 1'b1;
                    init_d     = 1'b1;
                    state_d    = StWaitHi;
                end else if (!empty_q) begin
                    pop     = 1'b1;
                    draw_d  = 1'b1;
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (ctrl_busy) begin
                    state_d = StWaitLo;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // tft_ctrl never acknowledged; retire the command and move on.
                    tmo_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            StWaitLo: begin
                if (!ctrl_busy) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A request landing on the issuing cycle stays pending rather than being lost.
    assign init_pend_d = (init_pend_q && !issue_init) || init_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            init_pend_q <= (AUTO_INIT != 0);
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
            init_q      <= 1'b0;
            draw_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            init_pend_q <= init_pend_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
            init_q      <= init_d;
            draw_q      <= draw_d;
            if (pop) begin
                out_q <= head;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign init    = init_q;
    assign draw    = draw_q;
    assign color   = out_q.color;
    assign xstart  = out_q.xs;
    assign xend    = out_q.xe;
    assign ystart  = out_q.ys;
    assign yend    = out_q.ye;
    assign tmo_err = tmo_err_q;
    assign idle    = (state_q == StIdle) && empty_q && !init_pend_q;

endmodule

// File: doc/tft_cmd_queue.md
Name: tft_cmd_queue

Overview:
Upstream command stage for tft_ctrl. Buffers rectangle-fill commands (color plus x/y window) from the application logic in a small FIFO. Issues the one-time screen init after reset, then replays queued commands as init/draw pulses using tft_ctrl's busy handshake. Holds color and window outputs stable for the whole fill, because tft_ctrl re-samples color on every pixel.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (each entry 80 bits: color, xstart, xend, ystart, yend).
AUTO_INIT, 1, 1 = issue init automatically after reset release; 0 = init only on init_req.
BUSY_TMO, 7, cycles to wait for ctrl_busy to rise after a pulse before flagging a timeout.
XMAX, 239, last valid column (used only when TFT_CMD_CLIP_EN is defined).
YMAX, 319, last valid row (used only when TFT_CMD_CLIP_EN is defined).

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
wr_en  in  1  push one command; ignored when full
wr_color  in  16  rrrrrggggggbbbbb fill color
wr_xstart  in  16  window first column
wr_xend  in  16  window last column
wr_ystart  in  16  window first row
wr_yend  in  16  window last row
init_req  in  1  request a display re-init (single-cycle pulse)
full  out  1  FIFO holds 2**DEPTH_LOG2 entries
empty  out  1  FIFO holds 0 entries
level  out  DEPTH_LOG2+1  current entry count
init  out  1  to tft_ctrl, one-cycle pulse
draw  out  1  to tft_ctrl, one-cycle pulse
ctrl_busy  in  1  from tft_ctrl busy
color, xstart, xend, ystart, yend  out  16 each  to tft_ctrl, held from draw pulse until the command retires
idle  out  1  sequencer in IDLE, FIFO empty, no init pending
tmo_err  out  1  sticky; set when ctrl_busy fails to rise within BUSY_TMO cycles; cleared only by reset

Behaviour:
- Reset values: all outputs 0 except empty=1. init_pend is set to AUTO_INIT. FIFO pointers are 0. State is IDLE.
- Reset asserted mid-operation aborts immediately. Outputs return to reset values, FIFO contents are discarded, and the pulse in flight is dropped.
- FIFO write:
  - wr_en && !full stores the entry at the write pointer.
  - A write when full is dropped silently; level is unchanged.
  - Pointers are DEPTH_LOG2+1 bits wide and wrap naturally. full/empty are derived from the pointers and registered with the pointers, so they are valid the cycle after the edge.
  - A write and a pop in the same cycle leave level unchanged, including when full (the pop frees a slot and the write is accepted).
- init_req sets init_pend. A request arriving while a draw is in progress is serviced after that draw retires. init_pend has priority over the FIFO.
- States:
  - IDLE: if init_pend, assert init for 1 cycle, clear init_pend, go to WAIT_HI. Else if !empty, pop the head into the output registers, assert draw for 1 cycle, go to WAIT_HI. The output registers are loaded on the same edge as the draw pulse.
  - WAIT_HI: count cycles. When ctrl_busy=1, go to WAIT_LO. When the count reaches BUSY_TMO with ctrl_busy still 0, set tmo_err and go to IDLE (the command is treated as retired).
  - WAIT_LO: when ctrl_busy=0, go to GAP.
  - GAP: one cycle so tft_ctrl returns to its idle state, then go to IDLE.
- init and draw are never asserted together. Minimum spacing between pulses is 4 cycles (pulse, busy rise, busy fall, GAP).
- idle = (state==IDLE) && empty && !init_pend.
- Coordinates and color pass through unmodified unless TFT_CMD_CLIP_EN is defined.

Optional Feature:
Macro TFT_CMD_CLIP_EN.
- Defined: the clip is applied at FIFO write.
  - If start>end on an axis, swap the two values.
  - Clamp end to XMAX/YMAX.
  - If start>XMAX (or >YMAX) after the swap, drop the command entirely: not stored, level unchanged.
- Not defined: no compare/clamp logic is built; values are stored verbatim.

Test Plan:
- Reset release, AUTO_INIT=1, bench model raises busy 1 cycle after init and lowers it 50 cycles later -> exactly one init pulse, no draw, idle=1 after GAP.
- Push 3 commands back-to-back (colors 0xF800, 0x07E0, 0x001F, window 0..9 x 0..9) -> 3 draw pulses in order, each with matching color/window held until its busy falls, level counts 3→0.
- Fill 16 entries, then push a 17th -> full=1, 17th dropped, level=16. Simultaneous push+pop when full -> level stays 16.
- init_req during a draw in progress -> the current draw completes, then the init pulse, then the remaining queued draws.
- ctrl_busy held 0 after a draw -> tmo_err=1 after 7 cycles, sequencer returns to IDLE and the next command issues.
- With TFT_CMD_CLIP_EN defined: push xstart=300,xend=10 -> stored as 10..239. Push xstart=250,xend=260 -> dropped, level unchanged.
